som_bmu_stream: RTL and testbench
=================================

Name: som_bmu_stream

Overview:
- Streaming best-matching-unit (BMU) search engine for the SOM processing system.
- Generalises the fixed 8x8 two-level combinational minimum tree into a parametrised, pipelined, handshaked unit.
- Accepts LANES neuron distances and weights per beat and accumulates a running minimum over a GRID_W x GRID_H map.
- Emits the winner's X/Y coordinates, distance and weight to the update-select and result-write logic.

Parameters:
- GRID_W, 8, map width in neurons; power of two, 2..64.
- GRID_H, 8, map height in neurons; power of two, 2..64.
- LANES, 8, neuron distances per input beat; power of two; divides GRID_W*GRID_H.
- DW, 10, distance width (unsigned).
- WW, 24, weight width (packed RGB).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- clr  in  1  synchronous frame abort; returns the block to IDLE
- in_valid  in  1  beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_dist  in  LANES*DW  lane distances; lane i in bits [i*DW +: DW]
- in_wgt  in  LANES*WW  lane weights; same packing as in_dist
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_x  out  log2(GRID_W)  winner column
- out_y  out  log2(GRID_H)  winner row
- out_dist  out  DW  winner distance
- out_wgt  out  WW  winner weight
- frame_cnt  out  16  completed frames, wraps at 65535 -> 0

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0 except in_ready=1. Beat counter, running minimum and frame_cnt are cleared.
- BEATS = GRID_W*GRID_H/LANES. A beat transfers when in_valid and in_ready are both high.
- Flat neuron index = beat_num*LANES + lane.
  - out_x = index[log2(GRID_W)-1:0]
  - out_y = index >> log2(GRID_W)
- Stage 1 (registered): a lane reduction tree picks the minimum distance in the beat. Ties go to the lower lane. The stage carries distance, weight, flat index and a last flag.
- Stage 2 (registered): running compare.
  - First beat of a frame loads unconditionally.
  - Later beats replace the held value only if strictly smaller, so the earliest index wins a tie.
- States:
  - IDLE: in_ready=1. The first accepted beat moves to ACC.
  - ACC: in_ready=1. The beat with beat_num=BEATS-1 moves to DRAIN, and in_ready drops the next cycle.
  - DRAIN: in_ready=0. Waits for the last beat to leave stage 2, then moves to HOLD with out_valid=1.
  - HOLD: out_valid=1 and outputs are stable until out_ready=1. On handoff: out_valid=0, frame_cnt+1, go to IDLE.
- If BEATS=1, the first accepted beat goes straight to DRAIN.
- Latency: last beat accepted at cycle T -> out_valid=1 at T+2, provided stages hold no stall. No bubbles are needed between beats.
- Back-to-back frames: in_ready stays 0 from T+1 until the cycle after the handoff. Result outputs are not double-buffered.
- clr=1 in any state:
  - next cycle IDLE; pipeline valid bits, beat counter and running minimum cleared; out_valid=0.
  - frame_cnt unchanged.
  - clr takes priority over a simultaneous beat or handoff; neither takes effect.
- in_valid high while in_ready=0: ignored, no state change.
- Distances are unsigned and compared at full DW; there is no saturation.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is discarded.

Decomposition:
- Shared package som_pkg holds:
  - constants: default GRID_W, GRID_H, DW, WW
  - state encoding: IDLE, ACC, DRAIN, HOLD
  - a function clog2 for index widths
- One sub-module, som_lane_min: registered LANES-input minimum tree (distance, weight, lane index) with lower-lane tie-break. It is reusable by a future multi-image variant.

Test Plan:
- Defaults (8x8, LANES=8): 8 beats, all distances 500 except neuron 37 = 12 (weight 24'hABCDEF) -> out_x=5, out_y=4, out_dist=12, out_wgt=24'hABCDEF; out_valid exactly 2 cycles after the last beat.
- Tie: neurons 9 and 50 both = 3, all others 1023 -> index 9 wins: out_x=1, out_y=1. Repeat with lanes 2 and 5 of beat 0 both = 3 -> out_x=2, out_y=0.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid rises -> outputs stable, in_ready=0 throughout. out_ready=1 -> frame_cnt 0->1, in_ready=1 the following cycle.
- Abort: clr pulse after beat 4, then a full new frame whose minimum is neuron 0 = 7 -> result (0,0,7) with no contamination from the aborted beats; frame_cnt increments once.
- Parameter sweep: GRID_W=16, GRID_H=4, LANES=2, with minimum at neuron 63 -> out_x=15, out_y=3 after 32 beats. Also LANES=64 (BEATS=1): result 2 cycles after the single beat.
- Async reset asserted in HOLD -> out_valid=0, in_ready=1, frame_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/som_pkg.sv
// Shared definitions for the SOM best-matching-unit search slice.
// Contents:
//   DEF_*   default map geometry, lane count and data widths
//   state_e controller states of the streaming BMU engine
//   clog2   ceiling log2, used to size index and counter fields
package som_pkg;

   localparam int DEF_GRID_W = 8;
   localparam int DEF_GRID_H = 8;
   localparam int DEF_LANES  = 8;
   localparam int DEF_DW     = 10;
   localparam int DEF_WW     = 24;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACC   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/som_bmu_stream_if.sv
// Beat-input / result-output bundle of the streaming BMU engine.
//   in_valid/in_ready       beat handshake
//   in_dist/in_wgt          LANES packed distances and weights (lane i at [i*W +: W])
//   out_valid/out_ready     result handshake
//   out_x/out_y             winner column / row
//   out_dist/out_wgt        winner distance / weight
// master drives beats and accepts results; slave is the engine.
interface som_bmu_stream_if #(
   parameter int LANES = 8,
   parameter int DW    = 10,
   parameter int WW    = 24,
   parameter int XW    = 3,
   parameter int YW    = 3
);

   logic                in_valid;
   logic                in_ready;
   logic [LANES*DW-1:0] in_dist;
   logic [LANES*WW-1:0] in_wgt;
   logic                out_valid;
   logic                out_ready;
   logic [XW-1:0]       out_x;
   logic [YW-1:0]       out_y;
   logic [DW-1:0]       out_dist;
   logic [WW-1:0]       out_wgt;

   modport master (
      output in_valid, in_dist, in_wgt, out_ready,
      input  in_ready, out_valid, out_x, out_y, out_dist, out_wgt
   );

   modport slave (
      input  in_valid, in_dist, in_wgt, out_ready,
      output in_ready, out_valid, out_x, out_y, out_dist, out_wgt
   );

endinterface

// File: rtl/som_lane_min.sv
// Registered LANES-input minimum tree.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr_i           synchronous flush of the valid bit
//   vld_i           input beat valid
//   dist_i, wgt_i   packed lane distances / weights
//   vld_o           registered result valid
//   dist_o, wgt_o   minimum distance and its weight
//   lane_o          lane that held the minimum (lowest lane on ties)
module som_lane_min
   import som_pkg::*;
#(
   parameter int LANES = DEF_LANES,
   parameter int DW    = DEF_DW,
   parameter int WW    = DEF_WW,
   parameter int LW    = (clog2(LANES) > 0) ? clog2(LANES) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr_i,
   input  logic                vld_i,
   input  logic [LANES*DW-1:0] dist_i,
   input  logic [LANES*WW-1:0] wgt_i,
   output logic                vld_o,
   output logic [DW-1:0]       dist_o,
   output logic [WW-1:0]       wgt_o,
   output logic [LW-1:0]       lane_o
);

   // Heap-ordered tree: node n has children 2n (lower lanes) and 2n+1.
   // Leaves sit at LANES..2*LANES-1, the root at node 1.
   logic [DW-1:0] nd [2*LANES];
   logic [WW-1:0] nw [2*LANES];
   logic [LW-1:0] nl [2*LANES];

   logic          vld_p1_q;
   logic [DW-1:0] dist_p1_q;
   logic [WW-1:0] wgt_p1_q;
   logic [LW-1:0] lane_p1_q;

   always_comb begin
      for (int n = 0; n < LANES; n++) begin
         nd[n] = '0;
         nw[n] = '0;
         nl[n] = '0;
      end
      for (int l = 0; l < LANES; l++) begin
         nd[LANES+l] = dist_i[l*DW +: DW];
         nw[LANES+l] = wgt_i[l*WW +: WW];
         nl[LANES+l] = LW'(l);
      end
      // Right child wins only when strictly smaller, so ties keep the lower lane.
      for (int n = LANES - 1; n >= 1; n--) begin
         if (nd[2*n+1] < nd[2*n]) begin
            nd[n] = nd[2*n+1];
            nw[n] = nw[2*n+1];
            nl[n] = nl[2*n+1];
         end else begin
            nd[n] = nd[2*n];
            nw[n] = nw[2*n];
            nl[n] = nl[2*n];
         end
      end
   end

   // ---- stage 1 boundary ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_p1_q <= 1'b0;
      else        vld_p1_q <= vld_i & ~clr_i;
   end

   always_ff @(posedge clk) begin
      if (vld_i) begin
         dist_p1_q <= nd[1];
         wgt_p1_q  <= nw[1];
         lane_p1_q <= nl[1];
      end
   end

   assign vld_o  = vld_p1_q;
   assign dist_o = dist_p1_q;
   assign wgt_o  = wgt_p1_q;
   assign lane_o = lane_p1_q;

endmodule

// File: rtl/som_bmu_stream.sv
// Streaming best-matching-unit search over a GRID_W x GRID_H map.
// Ports:
//   clk         clock
//   rst         asynchronous active-low reset
//   clr         synchronous frame abort, returns to IDLE
//   bus         beat input / result output bundle (slave side)
//   frame_cnt   completed-frame counter, wraps
// Pipeline: lane minimum tree (stage 1) -> running frame minimum (stage 2).
// The running-minimum registers are the result outputs; they are held
// while the result waits for the consumer because no beat is accepted then.
module som_bmu_stream
   import som_pkg::*;
#(
   parameter int GRID_W = DEF_GRID_W,
   parameter int GRID_H = DEF_GRID_H,
   parameter int LANES  = DEF_LANES,
   parameter int DW     = DEF_DW,
   parameter int WW     = DEF_WW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   som_bmu_stream_if.slave   bus,
   output logic [15:0]       frame_cnt
);

   localparam int BEATS = (GRID_W * GRID_H) / LANES;
   localparam int XW    = clog2(GRID_W);
   localparam int YW    = clog2(GRID_H);
   localparam int IW    = XW + YW;
   localparam int LSW   = clog2(LANES);
   localparam int LW    = (LSW > 0) ? LSW : 1;
   localparam int BW    = (clog2(BEATS) > 0) ? clog2(BEATS) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   state_e        state_q;
   logic          in_ready_q;
   logic          out_valid_q;
   logic [15:0]   frame_cnt_q;
   logic [BW-1:0] beat_q;

   logic          accept;
   logic          beat_last;

   logic          vld_p1;
   logic [DW-1:0] dist_p1;
   logic [WW-1:0] wgt_p1;
   logic [LW-1:0] lane_p1;
   logic [IW-1:0] base_p1_q;
   logic          last_p1_q;
   logic          first_p1_q;

   logic [DW-1:0] min_dist_q;
   logic [WW-1:0] min_wgt_q;
   logic [IW-1:0] min_idx_q;

   assign accept    = bus.in_valid & in_ready_q & ~clr;
   assign beat_last = (beat_q == LAST_BEAT);

   som_lane_min #(
      .LANES (LANES),
      .DW    (DW),
      .WW    (WW),
      .LW    (LW)
   ) u_lane_min (
      .clk    (clk),
      .rst_n  (rst),
      .clr_i  (clr),
      .vld_i  (accept),
      .dist_i (bus.in_dist),
      .wgt_i  (bus.in_wgt),
      .vld_o  (vld_p1),
      .dist_o (dist_p1),
      .wgt_o  (wgt_p1),
      .lane_o (lane_p1)
   );

   // ---- stage 1 boundary: beat position travels with the lane minimum ----
   always_ff @(posedge clk) begin
      if (accept) begin
         base_p1_q  <= IW'(beat_q) << LSW;
         last_p1_q  <= beat_last;
         first_p1_q <= (beat_q == '0);
      end
   end

   // ---- stage 2 boundary: running minimum; strict compare keeps the earliest index ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         min_dist_q <= '0;
         min_wgt_q  <= '0;
         min_idx_q  <= '0;
      end else if (clr) begin
         min_dist_q <= '0;
         min_wgt_q  <= '0;
         min_idx_q  <= '0;
      end else if (vld_p1 && (first_p1_q || (dist_p1 < min_dist_q))) begin
         min_dist_q <= dist_p1;
         min_wgt_q  <= wgt_p1;
         min_idx_q  <= base_p1_q | IW'(lane_p1);
      end
   end

   // Controller with registered handshake outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         frame_cnt_q <= '0;
         beat_q      <= '0;
      end else if (clr) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         beat_q      <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_ACC: begin
               if (accept) begin
                  if (beat_last) begin
                     beat_q     <= '0;
                     state_q    <= ST_DRAIN;
                     in_ready_q <= 1'b0;
                  end else begin
                     beat_q  <= beat_q + 1'b1;
                     state_q <= ST_ACC;
                  end
               end
            end
            ST_DRAIN: begin
               // The final beat leaves stage 1 this cycle; its compare lands at this edge.
               if (vld_p1 && last_p1_q) begin
                  state_q     <= ST_HOLD;
                  out_valid_q <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (bus.out_ready) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  frame_cnt_q <= frame_cnt_q + 16'd1;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_x     = min_idx_q[XW-1:0];
   assign bus.out_y     = min_idx_q[IW-1:XW];
   assign bus.out_dist  = min_dist_q;
   assign bus.out_wgt   = min_wgt_q;
   assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_som_bmu_stream.sv
// Directed bench for som_bmu_stream: default 8x8/8-lane map, a 16x4/2-lane
// map and an 8x8/64-lane (single beat) map.
module tb_som_bmu_stream;
   import som_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr0, clr1, clr2;
   logic [15:0] fc0, fc1, fc2;
   int          errors = 0;
   int          checks = 0;
   int          exp_fc0 = 0;
   logic [9:0]  dmem [64];
   logic [23:0] wmem [64];

   always #5 clk = ~clk;

   som_bmu_stream_if #(.LANES(8),  .DW(10), .WW(24), .XW(3), .YW(3)) bus0();
   som_bmu_stream_if #(.LANES(2),  .DW(10), .WW(24), .XW(4), .YW(2)) bus1();
   som_bmu_stream_if #(.LANES(64), .DW(10), .WW(24), .XW(3), .YW(3)) bus2();

   som_bmu_stream #(.GRID_W(8), .GRID_H(8), .LANES(8), .DW(10), .WW(24)) u0 (
      .clk(clk), .rst(rst), .clr(clr0), .bus(bus0), .frame_cnt(fc0));
   som_bmu_stream #(.GRID_W(16), .GRID_H(4), .LANES(2), .DW(10), .WW(24)) u1 (
      .clk(clk), .rst(rst), .clr(clr1), .bus(bus1), .frame_cnt(fc1));
   som_bmu_stream #(.GRID_W(8), .GRID_H(8), .LANES(64), .DW(10), .WW(24)) u2 (
      .clk(clk), .rst(rst), .clr(clr2), .bus(bus2), .frame_cnt(fc2));

   task automatic fill_mem(input logic [9:0] d);
      for (int i = 0; i < 64; i++) begin
         dmem[i] = d;
         wmem[i] = 24'(i * 3);
      end
   endtask

   // Streams nbeats beats of dmem/wmem into u0; returns one cycle after the last transfer edge.
   task automatic send_frame0(input int nbeats);
      int g;
      for (int b = 0; b < nbeats; b++) begin
         for (int l = 0; l < 8; l++) begin
            bus0.in_dist[l*10 +: 10] = dmem[b*8+l];
            bus0.in_wgt[l*24 +: 24]  = wmem[b*8+l];
         end
         bus0.in_valid = 1'b1;
         g = 0;
         while (!bus0.in_ready && g < 50) begin
            @(posedge clk); #1; g++;
         end
         if (g >= 50) begin
            checks++; errors++;
            $display("FAIL send0_ready_timeout got in_ready=%b want 1", bus0.in_ready);
         end
         @(posedge clk); #1;
      end
      bus0.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if ({bus0.in_ready, bus0.out_valid, fc0} !== {1'b1, 1'b0, 16'd0}) begin
         errors++; $display("FAIL reset_ctrl got rdy/vld/fc=%b/%b/%0d want 1/0/0",
                            bus0.in_ready, bus0.out_valid, fc0);
      end
      checks++;
      if ({bus0.out_x, bus0.out_y, bus0.out_dist, bus0.out_wgt} !== 40'd0) begin
         errors++; $display("FAIL reset_data got %h want 0",
                            {bus0.out_x, bus0.out_y, bus0.out_dist, bus0.out_wgt});
      end
      checks++;
      if ({bus1.in_ready, bus1.out_valid, bus2.in_ready, bus2.out_valid} !== 4'b1010) begin
         errors++; $display("FAIL reset_sweep got %b want 1010",
                            {bus1.in_ready, bus1.out_valid, bus2.in_ready, bus2.out_valid});
      end
   endtask

   task automatic test_basic();
      fill_mem(10'd500);
      dmem[37] = 10'd12; wmem[37] = 24'hABCDEF;
      send_frame0(8);
      checks++;
      if ({bus0.out_valid, bus0.in_ready} !== 2'b00) begin
         errors++; $display("FAIL basic_t1 got vld/rdy=%b want 00", {bus0.out_valid, bus0.in_ready});
      end
      @(posedge clk); #1;
      checks++;
      if (bus0.out_valid !== 1'b1) begin
         errors++; $display("FAIL basic_t2_valid got %b want 1", bus0.out_valid);
      end
      checks++;
      if ({bus0.out_x, bus0.out_y, bus0.out_dist, bus0.out_wgt} !== {3'd5, 3'd4, 10'd12, 24'hABCDEF}) begin
         errors++; $display("FAIL basic_result got x=%0d y=%0d d=%0d w=%h want 5 4 12 abcdef",
                            bus0.out_x, bus0.out_y, bus0.out_dist, bus0.out_wgt);
      end
      bus0.out_ready = 1'b1; @(posedge clk); #1; bus0.out_ready = 1'b0; exp_fc0++;
      checks++;
      if ({bus0.out_valid, bus0.in_ready, fc0} !== {1'b0, 1'b1, exp_fc0[15:0]}) begin
         errors++; $display("FAIL basic_handoff got vld/rdy/fc=%b/%b/%0d want 0/1/%0d",
                            bus0.out_valid, bus0.in_ready, fc0, exp_fc0);
      end
   endtask

   task automatic test_tie();
      fill_mem(10'd1023);
      dmem[9] = 10'd3; dmem[50] = 10'd3;
      send_frame0(8);
      @(posedge clk); #1;
      checks++;
      if ({bus0.out_valid, bus0.out_x, bus0.out_y, bus0.out_dist, bus0.out_wgt}
          !== {1'b1, 3'd1, 3'd1, 10'd3, 24'd27}) begin
         errors++; $display("FAIL tie_beats got v=%b x=%0d y=%0d d=%0d w=%0d want 1 1 1 3 27",
                            bus0.out_valid, bus0.out_x, bus0.out_y, bus0.out_dist, bus0.out_wgt);
      end
      bus0.out_ready = 1'b1; @(posedge clk); #1; bus0.out_ready = 1'b0; exp_fc0++;
      fill_mem(10'd1023);
      dmem[2] = 10'd3; dmem[5] = 10'd3;
      send_frame0(8);
      @(posedge clk); #1;
      checks++;
      if ({bus0.out_valid, bus0.out_x, bus0.out_y, bus0.out_dist, bus0.out_wgt}
          !== {1'b1, 3'd2, 3'd0, 10'd3, 24'd6}) begin
         errors++; $display("FAIL tie_lanes got v=%b x=%0d y=%0d d=%0d w=%0d want 1 2 0 3 6",
                            bus0.out_valid, bus0.out_x, bus0.out_y, bus0.out_dist, bus0.out_wgt);
      end
      bus0.out_ready = 1'b1; @(posedge clk); #1; bus0.out_ready = 1'b0; exp_fc0++;
      checks++;
      if (fc0 !== exp_fc0[15:0]) begin
         errors++; $display("FAIL tie_frame_cnt got %0d want %0d", fc0, exp_fc0);
      end
   endtask

   task automatic test_backpressure();
      fill_mem(10'd500);
      dmem[20] = 10'd100;
      send_frame0(8);
      @(posedge clk); #1;
      // A beat offered while the result waits must be ignored.
      for (int l = 0; l < 8; l++) bus0.in_dist[l*10 +: 10] = 10'd1;
      bus0.in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         checks++;
         if ({bus0.out_valid, bus0.in_ready, bus0.out_x, bus0.out_y, bus0.out_dist, bus0.out_wgt}
             !== {1'b1, 1'b0, 3'd4, 3'd2, 10'd100, 24'd60}) begin
            errors++; $display("FAIL bp_hold_c%0d got v=%b r=%b x=%0d y=%0d d=%0d w=%0d want 1 0 4 2 100 60",
                               c, bus0.out_valid, bus0.in_ready, bus0.out_x, bus0.out_y,
                               bus0.out_dist, bus0.out_wgt);
         end
         @(posedge clk); #1;
      end
      bus0.in_valid = 1'b0;
      bus0.out_ready = 1'b1; @(posedge clk); #1; bus0.out_ready = 1'b0; exp_fc0++;
      checks++;
      if ({bus0.out_valid, bus0.in_ready, fc0} !== {1'b0, 1'b1, exp_fc0[15:0]}) begin
         errors++; $display("FAIL bp_handoff got vld/rdy/fc=%b/%b/%0d want 0/1/%0d",
                            bus0.out_valid, bus0.in_ready, fc0, exp_fc0);
      end
   endtask

   task automatic test_abort();
      fill_mem(10'd600);
      dmem[3] = 10'd1;
      send_frame0(5);
      clr0 = 1'b1; @(posedge clk); #1; clr0 = 1'b0;
      checks++;
      if ({bus0.out_valid, bus0.in_ready, fc0, bus0.out_dist} !== {1'b0, 1'b1, exp_fc0[15:0], 10'd0}) begin
         errors++; $display("FAIL abort_clr got v=%b r=%b fc=%0d d=%0d want 0 1 %0d 0",
                            bus0.out_valid, bus0.in_ready, fc0, bus0.out_dist, exp_fc0);
      end
      fill_mem(10'd600);
      dmem[0] = 10'd7;
      send_frame0(8);
      @(posedge clk); #1;
      checks++;
      if ({bus0.out_valid, bus0.out_x, bus0.out_y, bus0.out_dist, bus0.out_wgt}
          !== {1'b1, 3'd0, 3'd0, 10'd7, 24'd0}) begin
         errors++; $display("FAIL abort_result got v=%b x=%0d y=%0d d=%0d w=%0d want 1 0 0 7 0",
                            bus0.out_valid, bus0.out_x, bus0.out_y, bus0.out_dist, bus0.out_wgt);
      end
      bus0.out_ready = 1'b1; @(posedge clk); #1; bus0.out_ready = 1'b0; exp_fc0++;
      checks++;
      if (fc0 !== exp_fc0[15:0]) begin
         errors++; $display("FAIL abort_frame_cnt got %0d want %0d", fc0, exp_fc0);
      end
   endtask

   task automatic test_sweep_16x4();
      int g;
      fill_mem(10'd900);
      dmem[63] = 10'd5; wmem[63] = 24'h123456;
      for (int b = 0; b < 32; b++) begin
         for (int l = 0; l < 2; l++) begin
            bus1.in_dist[l*10 +: 10] = dmem[b*2+l];
            bus1.in_wgt[l*24 +: 24]  = wmem[b*2+l];
         end
         bus1.in_valid = 1'b1;
         g = 0;
         while (!bus1.in_ready && g < 50) begin
            @(posedge clk); #1; g++;
         end
         if (g >= 50) begin
            checks++; errors++;
            $display("FAIL send1_ready_timeout got in_ready=%b want 1", bus1.in_ready);
         end
         @(posedge clk); #1;
      end
      bus1.in_valid = 1'b0;
      checks++;
      if ({bus1.out_valid, bus1.in_ready} !== 2'b00) begin
         errors++; $display("FAIL sweep_t1 got vld/rdy=%b want 00", {bus1.out_valid, bus1.in_ready});
      end
      @(posedge clk); #1;
      checks++;
      if ({bus1.out_valid, bus1.out_x, bus1.out_y, bus1.out_dist, bus1.out_wgt}
          !== {1'b1, 4'd15, 2'd3, 10'd5, 24'h123456}) begin
         errors++; $display("FAIL sweep_result got v=%b x=%0d y=%0d d=%0d w=%h want 1 15 3 5 123456",
                            bus1.out_valid, bus1.out_x, bus1.out_y, bus1.out_dist, bus1.out_wgt);
      end
      bus1.out_ready = 1'b1; @(posedge clk); #1; bus1.out_ready = 1'b0;
      checks++;
      if ({bus1.out_valid, bus1.in_ready, fc1} !== {1'b0, 1'b1, 16'd1}) begin
         errors++; $display("FAIL sweep_handoff got v=%b r=%b fc=%0d want 0 1 1",
                            bus1.out_valid, bus1.in_ready, fc1);
      end
   endtask

   task automatic test_single_beat();
      fill_mem(10'd800);
      dmem[42] = 10'd2; wmem[42] = 24'h00BEEF;
      for (int l = 0; l < 64; l++) begin
         bus2.in_dist[l*10 +: 10] = dmem[l];
         bus2.in_wgt[l*24 +: 24]  = wmem[l];
      end
      bus2.in_valid = 1'b1;
      @(posedge clk); #1;
      bus2.in_valid = 1'b0;
      checks++;
      if ({bus2.out_valid, bus2.in_ready} !== 2'b00) begin
         errors++; $display("FAIL single_t1 got vld/rdy=%b want 00", {bus2.out_valid, bus2.in_ready});
      end
      @(posedge clk); #1;
      checks++;
      if ({bus2.out_valid, bus2.out_x, bus2.out_y, bus2.out_dist, bus2.out_wgt}
          !== {1'b1, 3'd2, 3'd5, 10'd2, 24'h00BEEF}) begin
         errors++; $display("FAIL single_result got v=%b x=%0d y=%0d d=%0d w=%h want 1 2 5 2 00beef",
                            bus2.out_valid, bus2.out_x, bus2.out_y, bus2.out_dist, bus2.out_wgt);
      end
      bus2.out_ready = 1'b1; @(posedge clk); #1; bus2.out_ready = 1'b0;
      checks++;
      if ({bus2.out_valid, bus2.in_ready, fc2} !== {1'b0, 1'b1, 16'd1}) begin
         errors++; $display("FAIL single_handoff got v=%b r=%b fc=%0d want 0 1 1",
                            bus2.out_valid, bus2.in_ready, fc2);
      end
   endtask

   task automatic test_async_reset();
      fill_mem(10'd500);
      dmem[11] = 10'd9;
      send_frame0(8);
      @(posedge clk); #1;
      checks++;
      if ({bus0.out_valid, fc0} !== {1'b1, exp_fc0[15:0]}) begin
         errors++; $display("FAIL areset_pre got v=%b fc=%0d want 1 %0d", bus0.out_valid, fc0, exp_fc0);
      end
      #3 rst = 1'b0;
      #1;
      exp_fc0 = 0;
      checks++;
      if ({bus0.out_valid, bus0.in_ready, fc0, bus0.out_dist} !== {1'b0, 1'b1, 16'd0, 10'd0}) begin
         errors++; $display("FAIL areset_now got v=%b r=%b fc=%0d d=%0d want 0 1 0 0",
                            bus0.out_valid, bus0.in_ready, fc0, bus0.out_dist);
      end
      checks++;
      if ({fc1, fc2} !== 32'd0) begin
         errors++; $display("FAIL areset_others got fc1=%0d fc2=%0d want 0 0", fc1, fc2);
      end
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({bus0.out_valid, bus0.in_ready, fc0} !== {1'b0, 1'b1, 16'd0}) begin
         errors++; $display("FAIL areset_release got v=%b r=%b fc=%0d want 0 1 0",
                            bus0.out_valid, bus0.in_ready, fc0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
      bus0.in_valid = 1'b0; bus0.out_ready = 1'b0; bus0.in_dist = '0; bus0.in_wgt = '0;
      bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.in_dist = '0; bus1.in_wgt = '0;
      bus2.in_valid = 1'b0; bus2.out_ready = 1'b0; bus2.in_dist = '0; bus2.in_wgt = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_tie();
      test_backpressure();
      test_abort();
      test_sweep_16x4();
      test_single_beat();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
